// File: rtl/gpio_cmd_master.sv
// gpio_cmd_master: hardware initiator for the DSP GPIO command protocol (single commands and RAM burst reads).
// Optional response stall timeout is enabled by defining GPIO_MASTER_RSP_TIMEOUT_EN.
module gpio_cmd_master #(
   parameter int NBT_GPIOS   = 32,
   parameter int NBT_ADRS    = 16,
   parameter int HOLD_CYC    = 4,
   parameter int SETTLE_CYC  = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 i_reset,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic [7:0]           i_cmd_opc,
   input  logic [22:0]          i_cmd_data,
   input  logic                 i_cmd_burst,
   input  logic [NBT_ADRS-1:0]  i_burst_adrs,
   input  logic [15:0]          i_burst_len,
   output logic [NBT_GPIOS-1:0] o_gpio_to_dsp,
   input  logic [NBT_GPIOS-1:0] i_gpio_from_dsp,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [NBT_GPIOS-1:0] o_rsp_data,
   output logic                 o_rsp_last,
   output logic                 o_busy,
   output logic                 o_timeout
);

   // state     | meaning
   // S_IDLE    | bus parked at 0, ready for a command
   // S_ISSUE   | frame driven with en=1 for HOLD_CYC cycles
   // S_SETTLE  | frame driven with en=0 for SETTLE_CYC cycles
   // S_CAPTURE | one cycle, GPIO read word registered
   // S_RESP    | response word offered until handshake (or timeout)
   // S_CLOSE   | burst teardown frame (RAM read disabled) for HOLD_CYC cycles
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_SETTLE, S_CAPTURE, S_RESP, S_CLOSE
   } state_t;

   localparam int TMAX = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
   localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
   localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYC - 1);
   localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
   localparam logic [7:0]    OPC_RAM_RD = 8'h04;
   localparam logic [22:0]   RD_EN      = 23'h010000;

   state_t                state_q, state_d;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic [7:0]            opc_q, opc_d;
   logic [22:0]           pay_q, pay_d;
   logic                  burst_q, burst_d;
   logic [NBT_ADRS-1:0]   adrs_q, adrs_d;
   logic [15:0]           rem_q, rem_d;
   logic [NBT_GPIOS-1:0]  rsp_data_q, rsp_data_d;

   logic                  tmr_done;
   logic                  word_last;
   logic                  to_expire;
   logic                  rsp_done;
   logic [22:0]           payload;

   assign tmr_done  = (tmr_q == '0);
   assign word_last = !burst_q || (rem_q == 16'd1);
   assign payload   = burst_q ? (RD_EN | 23'(adrs_q)) : pay_q;
   assign rsp_done  = i_rsp_ready || to_expire;

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      opc_d      = opc_q;
      pay_d      = pay_q;
      burst_d    = burst_q;
      adrs_d     = adrs_q;
      rem_d      = rem_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         S_IDLE: begin
            if (i_cmd_valid) begin
               burst_d = i_cmd_burst;
               tmr_d   = HOLD_LD;
               if (i_cmd_burst) begin
                  opc_d   = OPC_RAM_RD;
                  adrs_d  = i_burst_adrs;
                  rem_d   = i_burst_len;
                  state_d = (i_burst_len == 16'd0) ? S_CLOSE : S_ISSUE;
               end else begin
                  opc_d   = i_cmd_opc;
                  pay_d   = i_cmd_data;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (tmr_done) begin
               tmr_d   = SETTLE_LD;
               state_d = S_SETTLE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_SETTLE: begin
            if (tmr_done) state_d = S_CAPTURE;
            else          tmr_d   = tmr_q - TW'(1);
         end
         S_CAPTURE: begin
            rsp_data_d = i_gpio_from_dsp;
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (rsp_done) begin
               tmr_d = HOLD_LD;
               if (!burst_q) begin
                  state_d = S_IDLE;
               end else if (word_last) begin
                  state_d = S_CLOSE;
               end else begin
                  // next RAM word; address wraps naturally at the top
                  adrs_d  = adrs_q + NBT_ADRS'(1);
                  rem_d   = rem_q - 16'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_CLOSE: begin
            if (tmr_done) state_d = S_IDLE;
            else          tmr_d   = tmr_q - TW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!i_reset) begin
         state_q    <= S_IDLE;
         tmr_q      <= '0;
         opc_q      <= '0;
         pay_q      <= '0;
         burst_q    <= 1'b0;
         adrs_q     <= '0;
         rem_q      <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         opc_q      <= opc_d;
         pay_q      <= pay_d;
         burst_q    <= burst_d;
         adrs_q     <= adrs_d;
         rem_q      <= rem_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   // The settle frame stays on the bus through capture and response so the DSP holds its read word.
   always_comb begin
      o_gpio_to_dsp = '0;
      case (state_q)
         S_ISSUE:                    o_gpio_to_dsp = NBT_GPIOS'({opc_q, 1'b1, payload});
         S_SETTLE, S_CAPTURE, S_RESP: o_gpio_to_dsp = NBT_GPIOS'({opc_q, 1'b0, payload});
         S_CLOSE:                    o_gpio_to_dsp = NBT_GPIOS'({OPC_RAM_RD, 1'b1, 23'h0});
         default:                    o_gpio_to_dsp = '0;
      endcase
   end

   assign o_cmd_ready = (state_q == S_IDLE);
   assign o_busy      = !o_cmd_ready;
   assign o_rsp_valid = (state_q == S_RESP);
   assign o_rsp_data  = rsp_data_q;
   assign o_rsp_last  = (state_q == S_RESP) && word_last;

`ifdef GPIO_MASTER_RSP_TIMEOUT_EN
   localparam int TOW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [TOW-1:0] TO_LD = TOW'(TIMEOUT_CYC - 1);

   logic [TOW-1:0] to_q, to_d;
   logic           timeout_q, timeout_d;

   assign to_expire = (state_q == S_RESP) && !i_rsp_ready && (to_q == '0);

   always_comb begin
      to_d      = to_q;
      timeout_d = timeout_q;
      if (state_q == S_CAPTURE)
         to_d = TO_LD;
      else if ((state_q == S_RESP) && !i_rsp_ready && (to_q != '0))
         to_d = to_q - TOW'(1);
      if (to_expire)
         timeout_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!i_reset) begin
         to_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_q      <= to_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign to_expire = 1'b0;
   assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_cmd_master.sv
// Scoreboard bench for gpio_cmd_master: queued expected frames/responses checked by independent monitors.
module tb_gpio_cmd_master;
   localparam int HOLD   = 4;
   localparam int SETTLE = 2;
   localparam int TOCYC  = 16;
`ifdef GPIO_MASTER_RSP_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
   localparam int STALL = 12;
`else
   localparam bit TO_EN = 1'b0;
   localparam int STALL = 20;
`endif

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic [7:0]  i_cmd_opc;
   logic [22:0] i_cmd_data;
   logic        i_cmd_burst;
   logic [15:0] i_burst_adrs;
   logic [15:0] i_burst_len;
   logic [31:0] o_gpio_to_dsp;
   logic [31:0] i_gpio_from_dsp;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_data;
   logic        o_rsp_last;
   logic        o_busy;
   logic        o_timeout;

   always #5 clk = ~clk;

   // DSP model: returns garbage while en is still high, otherwise a salted copy of the frame
   logic [31:0] salt;
   assign i_gpio_from_dsp = o_gpio_to_dsp[23] ? 32'hDEADDEAD : (o_gpio_to_dsp ^ salt);

   gpio_cmd_master #(
      .NBT_GPIOS(32), .NBT_ADRS(16), .HOLD_CYC(HOLD), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TOCYC)
   ) dut (
      .clk(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_opc(i_cmd_opc), .i_cmd_data(i_cmd_data), .i_cmd_burst(i_cmd_burst),
      .i_burst_adrs(i_burst_adrs), .i_burst_len(i_burst_len), .o_gpio_to_dsp(o_gpio_to_dsp),
      .i_gpio_from_dsp(i_gpio_from_dsp), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_data(o_rsp_data), .o_rsp_last(o_rsp_last), .o_busy(o_busy), .o_timeout(o_timeout)
   );

   typedef struct packed { logic [31:0] d; logic last; } rsp_t;
   typedef struct { logic [31:0] v; int lo; int hi; } run_t;
   rsp_t rsp_q[$];
   run_t run_q[$];
   int checks = 0;
   int passes = 0;

   function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, required %h", n, act, exp);
   endfunction

   function automatic void chk_rng(string n, int act, int lo, int hi);
      checks++;
      if (act >= lo && act <= hi) passes++;
      else $display("FAIL %s: got %0d, required %0d..%0d", n, act, lo, hi);
   endfunction

   function automatic void push_single(logic [7:0] opc, logic [22:0] data);
      logic [31:0] st;
      st = {opc, 1'b0, data};
      run_q.push_back('{{opc, 1'b1, data}, HOLD, HOLD});
      run_q.push_back('{st, SETTLE + 2, 100000});
      rsp_q.push_back({st ^ salt, 1'b1});
   endfunction

   function automatic void push_burst(logic [15:0] a, int len, bit drop_first);
      logic [15:0] ad;
      logic [31:0] st;
      for (int i = 0; i < len; i++) begin
         ad = a + 16'(i);
         st = 32'h04010000 | {16'h0, ad};
         run_q.push_back('{32'h04810000 | {16'h0, ad}, HOLD, HOLD});
         run_q.push_back('{st, SETTLE + 2, 100000});
         if (!(drop_first && i == 0)) rsp_q.push_back({st ^ salt, (i == len - 1)});
      end
      run_q.push_back('{32'h04800000, HOLD, HOLD});
   endfunction

   // ready driver
   int   rdy_mode = 1;
   logic rdy_manual = 1'b0;
   initial begin
      i_rsp_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       i_rsp_ready = rdy_manual;
            1:       i_rsp_ready = 1'b1;
            default: i_rsp_ready = ($urandom_range(3) != 0);
         endcase
      end
   end

   // response monitor
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (i_reset && o_rsp_valid && i_rsp_ready) begin
            if (rsp_q.size() == 0) begin
               checks++;
               $display("FAIL rsp_unexpected: got word %h, required no response", o_rsp_data);
            end else begin
               e = rsp_q.pop_front();
               chk("rsp_data", o_rsp_data, e.d);
               chk("rsp_last", {31'h0, o_rsp_last}, {31'h0, e.last});
            end
         end
      end
   end

   // frame monitor: compares each completed non-zero run of the bus value
   initial begin
      logic [31:0] cur_v;
      int          cur_len;
      run_t        r;
      cur_v = '0;
      cur_len = 0;
      forever begin
         @(negedge clk);
         if (!i_reset) begin
            cur_v = '0;
            cur_len = 0;
         end else if (o_gpio_to_dsp !== cur_v) begin
            if (cur_v != 32'h0) begin
               if (run_q.size() == 0) begin
                  checks++;
                  $display("FAIL frame_unexpected: got %h for %0d cycles, required none", cur_v, cur_len);
               end else begin
                  r = run_q.pop_front();
                  chk("frame_value", cur_v, r.v);
                  chk_rng("frame_cycles", cur_len, r.lo, r.hi);
               end
            end
            cur_v = o_gpio_to_dsp;
            cur_len = 1;
         end else begin
            cur_len++;
         end
      end
   end

   task automatic issue_cmd(bit burst, logic [7:0] opc, logic [22:0] data, logic [15:0] a, logic [15:0] len);
      int n = 0;
      while (!o_cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (!o_cmd_ready) chk("cmd_ready_wait", {31'h0, o_cmd_ready}, 32'h1);
      i_cmd_burst = burst; i_cmd_opc = opc; i_cmd_data = data;
      i_burst_adrs = a; i_burst_len = len; i_cmd_valid = 1'b1;
      @(posedge clk); #1;
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (o_busy && n < 1000) begin @(posedge clk); #1; n++; end
      chk("idle_reached", {31'h0, o_busy}, 32'h0);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!o_rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("rsp_valid_seen", {31'h0, o_rsp_valid}, 32'h1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, bad, vc;
      logic [15:0] a;
      logic [31:0] st;
      i_reset = 1'b0; i_cmd_valid = 1'b0; i_cmd_opc = '0; i_cmd_data = '0;
      i_cmd_burst = 1'b0; i_burst_adrs = '0; i_burst_len = '0; salt = '0;

      // reset
      repeat (3) @(posedge clk);
      #1;
      chk("reset_frame", o_gpio_to_dsp, 32'h0);
      chk("reset_ready", {31'h0, o_cmd_ready}, 32'h1);
      chk("reset_valid", {31'h0, o_rsp_valid}, 32'h0);
      chk("reset_busy", {31'h0, o_busy}, 32'h0);
      chk("reset_timeout", {31'h0, o_timeout}, 32'h0);
      i_reset = 1'b1;
      @(posedge clk); #1;

      // single command and its latency
      salt = 32'hCAFE0001 ^ 32'h06000008;
      push_single(8'h06, 23'h000008);
      issue_cmd(1'b0, 8'h06, 23'h000008, 16'h0, 16'h0);
      lat = 1;
      while (!o_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      chk("single_latency", lat, HOLD + SETTLE + 2);
      chk("single_rsp_word", o_rsp_data, 32'hCAFE0001);
      wait_idle();

      // burst across address wrap
      rdy_mode = 1;
      salt = $urandom;
      push_burst(16'hFFFE, 3, 1'b0);
      issue_cmd(1'b1, 8'h0, 23'h0, 16'hFFFE, 16'd3);
      wait_idle();

      // backpressure on first burst word
      rdy_mode = 0; rdy_manual = 1'b0;
      salt = $urandom;
      a = 16'($urandom);
      push_burst(a, 3, 1'b0);
      issue_cmd(1'b1, 8'h0, 23'h0, a, 16'd3);
      wait_valid();
      st = 32'h04010000 | {16'h0, a};
      bad = 0;
      for (int i = 0; i < STALL; i++) begin
         if (!o_rsp_valid || o_rsp_data !== (st ^ salt) || o_gpio_to_dsp !== st) bad++;
         @(posedge clk); #1;
      end
      chk("stall_hold_errors", bad, 0);
      rdy_manual = 1'b1;
      wait_idle();

      // response stall: dropped after TOCYC when the timeout is built in, held otherwise
      rdy_manual = 1'b0;
      salt = $urandom;
      a = 16'($urandom);
      push_burst(a, 2, TO_EN);
      issue_cmd(1'b1, 8'h0, 23'h0, a, 16'd2);
      wait_valid();
      vc = 0;
      while (o_rsp_valid && vc < 40) begin vc++; @(posedge clk); #1; end
      chk("stall_valid_cycles", vc, TO_EN ? TOCYC : 40);
      chk("timeout_flag", {31'h0, o_timeout}, {31'h0, TO_EN});
      rdy_manual = 1'b1;
      wait_idle();
      chk("timeout_sticky", {31'h0, o_timeout}, {31'h0, TO_EN});

      // reset on word 2 of 5
      rdy_mode = 1;
      salt = $urandom;
      a = 16'($urandom);
      push_burst(a, 5, 1'b0);
      issue_cmd(1'b1, 8'h0, 23'h0, a, 16'd5);
      vc = 0;
      while (o_gpio_to_dsp !== (32'h04810000 | {16'h0, 16'(a + 16'd1)}) && vc < 200) begin
         @(posedge clk); #1; vc++;
      end
      chk("word2_issue_seen", o_gpio_to_dsp, 32'h04810000 | {16'h0, 16'(a + 16'd1)});
      i_reset = 1'b0;
      @(posedge clk); #1;
      rsp_q.delete();
      run_q.delete();
      chk("abort_frame", o_gpio_to_dsp, 32'h0);
      chk("abort_ready", {31'h0, o_cmd_ready}, 32'h1);
      chk("abort_valid", {31'h0, o_rsp_valid}, 32'h0);
      chk("abort_rsp_data", o_rsp_data, 32'h0);
      chk("abort_timeout", {31'h0, o_timeout}, 32'h0);
      i_reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (o_gpio_to_dsp !== 32'h0 || o_busy) bad++;
         @(posedge clk); #1;
      end
      chk("no_close_after_reset", bad, 0);

      // randomized mix of singles and bursts with random backpressure
      rdy_mode = 2;
      for (int k = 0; k < 30; k++) begin
         salt = $urandom;
         if ($urandom_range(1) == 1) begin
            if ($urandom_range(1) == 1) a = 16'hFFFF - 16'($urandom_range(3));
            else                        a = 16'($urandom);
            lat = $urandom_range(5);
            push_burst(a, lat, 1'b0);
            issue_cmd(1'b1, 8'($urandom), 23'($urandom), a, 16'(lat));
         end else begin
            i_cmd_opc = 8'($urandom_range(255, 1));
            i_cmd_data = 23'($urandom);
            push_single(i_cmd_opc, i_cmd_data);
            issue_cmd(1'b0, i_cmd_opc, i_cmd_data, 16'($urandom), 16'($urandom));
         end
         wait_idle();
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rsp_queue_drained", rsp_q.size(), 0);
      chk("frame_queue_drained", run_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
